// File: rtl/network_mod_mi_arb.sv
// Round-robin MI arbiter with in-order read response routing.
// Optional read-response timeout: define NETWORK_MOD_MI_ARB_TIMEOUT_EN.
module network_mod_mi_arb #(
    parameter int REQUESTERS      = 2,
    parameter int MI_DATA_WIDTH   = 32,
    parameter int MI_ADDR_WIDTH   = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 1024
) (
    input  logic                                    CLK,
    input  logic                                    RESET,
    input  logic [REQUESTERS*MI_DATA_WIDTH-1:0]     IN_DWR,
    input  logic [REQUESTERS*MI_ADDR_WIDTH-1:0]     IN_ADDR,
    input  logic [REQUESTERS*MI_DATA_WIDTH/8-1:0]   IN_BE,
    input  logic [REQUESTERS-1:0]                   IN_RD,
    input  logic [REQUESTERS-1:0]                   IN_WR,
    output logic [REQUESTERS-1:0]                   IN_ARDY,
    output logic [REQUESTERS*MI_DATA_WIDTH-1:0]     IN_DRD,
    output logic [REQUESTERS-1:0]                   IN_DRDY,
    output logic [MI_DATA_WIDTH-1:0]                OUT_DWR,
    output logic [MI_ADDR_WIDTH-1:0]                OUT_ADDR,
    output logic [MI_DATA_WIDTH/8-1:0]              OUT_BE,
    output logic                                    OUT_RD,
    output logic                                    OUT_WR,
    input  logic                                    OUT_ARDY,
    input  logic [MI_DATA_WIDTH-1:0]                OUT_DRD,
    input  logic                                    OUT_DRDY
);

    localparam int IDW = $clog2(REQUESTERS);
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;
    localparam int BW  = MI_DATA_WIDTH / 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]              state;
    logic [IDW-1:0]          grant;
    logic [IDW-1:0]          ptr;
    logic [IDW-1:0]          pick;
    logic [IDW-1:0]          ptr_nxt;
    logic                    pick_vld;
    logic [REQUESTERS-1:0]   elig;
    logic                    busy;
    logic                    acc;
    logic                    g_rd;
    logic                    g_wr;

    logic [IDW-1:0]          fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]           wr_idx;
    logic [PW-1:0]           rd_idx;
    logic [CW-1:0]           count;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [IDW-1:0]          head;
    logic [MI_DATA_WIDTH-1:0] drd_val;

    assign busy  = (state == S_BUSY);
    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_idx];

    // A combined RD+WR request behaves as a read, so it obeys the FIFO limit.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            elig[i] = IN_RD[i] ? !full : IN_WR[i];
        end
    end

    always_comb begin
        int best;
        int d;
        best = REQUESTERS;
        pick = ptr;
        for (int i = 0; i < REQUESTERS; i++) begin
            d = (i >= int'(ptr)) ? i - int'(ptr)
                                 : i + REQUESTERS - int'(ptr);
            if (elig[i] && d < best) begin
                best = d;
                pick = IDW'(i);
            end
        end
        pick_vld = |elig;
    end

    always_comb begin
        OUT_DWR  = IN_DWR[MI_DATA_WIDTH-1:0];
        OUT_ADDR = IN_ADDR[MI_ADDR_WIDTH-1:0];
        OUT_BE   = IN_BE[BW-1:0];
        g_rd     = IN_RD[0];
        g_wr     = IN_WR[0];
        for (int i = 1; i < REQUESTERS; i++) begin
            if (grant == IDW'(i)) begin
                OUT_DWR  = IN_DWR[i*MI_DATA_WIDTH +: MI_DATA_WIDTH];
                OUT_ADDR = IN_ADDR[i*MI_ADDR_WIDTH +: MI_ADDR_WIDTH];
                OUT_BE   = IN_BE[i*BW +: BW];
                g_rd     = IN_RD[i];
                g_wr     = IN_WR[i];
            end
        end
    end

    assign OUT_RD  = busy && g_rd;
    assign OUT_WR  = busy && g_wr;
    assign acc     = busy && OUT_ARDY;
    assign push    = acc && g_rd;
    assign ptr_nxt = (grant == IDW'(REQUESTERS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            IN_ARDY[i] = acc && (grant == IDW'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant <= pick;
                        state <= S_BUSY;
                    end
                end
                default: begin
                    if (OUT_ARDY) begin
                        ptr   <= ptr_nxt;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef NETWORK_MOD_MI_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;
    logic [CW-1:0] stale;
    logic          expire;
    logic          discard;

    // A real DRDY always beats a same-cycle expiry.
    assign discard = OUT_DRDY && (stale != '0);
    assign expire  = !empty && !OUT_DRDY && (tcnt == TW'(TIMEOUT - 1));
    assign pop     = (OUT_DRDY && !discard && !empty) || expire;
    assign drd_val = expire ? '1 : OUT_DRD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tcnt  <= '0;
            stale <= '0;
        end else begin
            if (empty || pop) begin
                tcnt <= '0;
            end else if (tcnt != TW'(TIMEOUT - 1)) begin
                tcnt <= tcnt + 1'b1;
            end
            if (expire && stale != '1) begin
                stale <= stale + 1'b1;
            end else if (discard) begin
                stale <= stale - 1'b1;
            end
        end
    end
`else
    assign pop     = OUT_DRDY && !empty;
    assign drd_val = OUT_DRD;
`endif

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_idx] <= grant;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + 1'b1;
            end
            if (pop) begin
                rd_idx <= rd_idx + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        IN_DRDY = '0;
        IN_DRD  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (pop && head == IDW'(i)) begin
                IN_DRDY[i] = 1'b1;
                IN_DRD[i*MI_DATA_WIDTH +: MI_DATA_WIDTH] = drd_val;
            end
        end
    end

endmodule

// File: tb/tb_network_mod_mi_arb.sv
// Scoreboard bench for network_mod_mi_arb: expected accepts and
// read responses are queued by stimulus and checked by a monitor.
module tb_network_mod_mi_arb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [63:0] IN_DWR;
    logic [63:0] IN_ADDR;
    logic [7:0]  IN_BE;
    logic [1:0]  IN_RD;
    logic [1:0]  IN_WR;
    logic [1:0]  IN_ARDY;
    logic [63:0] IN_DRD;
    logic [1:0]  IN_DRDY;
    logic [31:0] OUT_DWR;
    logic [31:0] OUT_ADDR;
    logic [3:0]  OUT_BE;
    logic        OUT_RD;
    logic        OUT_WR;
    logic        OUT_ARDY;
    logic [31:0] OUT_DRD;
    logic        OUT_DRDY;

    typedef struct {
        int          req;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        int          gap;
    } acc_t;

    typedef struct {
        int          req;
        logic [31:0] data;
    } rsp_t;

    acc_t accq[$];
    rsp_t rspq[$];
    acc_t mon_a;
    rsp_t mon_r;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   last_rsp = 0;

    network_mod_mi_arb #(
        .REQUESTERS(2),
        .MI_DATA_WIDTH(32),
        .MI_ADDR_WIDTH(32),
        .MAX_OUTSTANDING(4),
        .TIMEOUT(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IN_DWR(IN_DWR),
        .IN_ADDR(IN_ADDR),
        .IN_BE(IN_BE),
        .IN_RD(IN_RD),
        .IN_WR(IN_WR),
        .IN_ARDY(IN_ARDY),
        .IN_DRD(IN_DRD),
        .IN_DRDY(IN_DRDY),
        .OUT_DWR(OUT_DWR),
        .OUT_ADDR(OUT_ADDR),
        .OUT_BE(OUT_BE),
        .OUT_RD(OUT_RD),
        .OUT_WR(OUT_WR),
        .OUT_ARDY(OUT_ARDY),
        .OUT_DRD(OUT_DRD),
        .OUT_DRDY(OUT_DRDY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic void exp_acc(input int r, input logic rd,
                                    input logic wr, input logic [31:0] a,
                                    input int g);
        acc_t t;
        t.req  = r;
        t.rd   = rd;
        t.wr   = wr;
        t.addr = a;
        t.gap  = g;
        accq.push_back(t);
    endfunction

    function automatic void exp_rsp(input int r, input logic [31:0] d);
        rsp_t t;
        t.req  = r;
        t.data = d;
        rspq.push_back(t);
    endfunction

    task automatic wait_acc(input int i);
        bit got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge CLK);
            got = IN_ARDY[i];
        end
        if (!got) chk("acc_timeout", 64'd0, 64'd1);
        @(posedge CLK);
        #1;
        IN_RD[i] = 1'b0;
        IN_WR[i] = 1'b0;
    endtask

    task automatic issue(input int i, input logic rd, input logic wr,
                         input logic [31:0] a);
        exp_acc(i, rd, wr, a, 0);
        IN_ADDR[i*32 +: 32] = a;
        IN_RD[i] = rd;
        IN_WR[i] = wr;
        wait_acc(i);
    endtask

    task automatic respond(input logic [31:0] d);
        OUT_DRD  = d;
        OUT_DRDY = 1'b1;
        tick(1);
        OUT_DRDY = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (IN_ARDY != 2'b00) begin
            if (accq.size() == 0) begin
                chk("acc_unexp", 64'(IN_ARDY), 64'd0);
            end else begin
                mon_a = accq.pop_front();
                chk("acc_req", 64'(IN_ARDY), 64'(2'b01 << mon_a.req));
                chk("acc_addr", 64'(OUT_ADDR), 64'(mon_a.addr));
                chk("acc_rd", 64'(OUT_RD), 64'(mon_a.rd));
                chk("acc_wr", 64'(OUT_WR), 64'(mon_a.wr));
                if (mon_a.gap != 0)
                    chk("acc_gap", 64'(cyc - last_acc), 64'(mon_a.gap));
            end
            last_acc = cyc;
        end
        if (IN_DRDY != 2'b00) begin
            if (rspq.size() == 0) begin
                chk("rsp_unexp", 64'(IN_DRDY), 64'd0);
            end else begin
                mon_r = rspq.pop_front();
                chk("rsp_req", 64'(IN_DRDY), 64'(2'b01 << mon_r.req));
                chk("rsp_data", IN_DRD, (mon_r.req == 1)
                    ? {mon_r.data, 32'h0} : {32'h0, mon_r.data});
            end
            last_rsp = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET    = 1'b1;
        IN_DWR   = {32'h2222_2222, 32'h1111_1111};
        IN_ADDR  = {32'h0000_0200, 32'h0000_0100};
        IN_BE    = 8'h3F;
        IN_RD    = 2'b00;
        IN_WR    = 2'b00;
        OUT_ARDY = 1'b0;
        OUT_DRD  = 32'h0;
        OUT_DRDY = 1'b0;
        tick(2);
        chk("rst_out_rd", 64'(OUT_RD), 64'd0);
        chk("rst_out_wr", 64'(OUT_WR), 64'd0);
        chk("rst_in_ardy", 64'(IN_ARDY), 64'd0);
        chk("rst_in_drdy", 64'(IN_DRDY), 64'd0);
        chk("rst_in_drd", IN_DRD, 64'd0);
        chk("rst_out_dwr", 64'(OUT_DWR), 64'h1111_1111);
        chk("rst_out_addr", 64'(OUT_ADDR), 64'h100);
        chk("rst_out_be", 64'(OUT_BE), 64'hF);
        RESET = 1'b0;

        // Continuous writes from both, slave always ready.
        OUT_ARDY = 1'b1;
        for (int k = 0; k < 6; k++)
            exp_acc(k % 2, 1'b0, 1'b1, (k % 2 == 1) ? 32'h200 : 32'h100,
                    (k == 0) ? 0 : 2);
        IN_WR = 2'b11;
        tick(12);
        IN_WR = 2'b00;
        tick(2);

        // Reads answered in issue order.
        exp_rsp(1, 32'h0000_AAAA);
        exp_rsp(0, 32'h0000_BBBB);
        issue(1, 1'b1, 1'b0, 32'h10);
        issue(0, 1'b1, 1'b0, 32'h20);
        tick(4);
        respond(32'h0000_AAAA);
        respond(32'h0000_BBBB);
        tick(1);

        // DRDY with nothing outstanding.
        OUT_DRD  = 32'h0000_CCCC;
        OUT_DRDY = 1'b1;
        #1;
        chk("empty_drdy", 64'(IN_DRDY), 64'd0);
        chk("empty_drd", IN_DRD, 64'd0);
        chk("empty_state", 64'(OUT_RD), 64'd0);
        tick(1);
        OUT_DRDY = 1'b0;
        tick(1);

        // Fill the FIFO, then a read and a write compete.
        exp_rsp(0, 32'h1);
        exp_rsp(0, 32'h2);
        exp_rsp(1, 32'h3);
        exp_rsp(1, 32'h4);
        exp_rsp(0, 32'h5);
        issue(0, 1'b1, 1'b0, 32'h30);
        issue(0, 1'b1, 1'b0, 32'h34);
        issue(1, 1'b1, 1'b0, 32'h38);
        issue(1, 1'b1, 1'b0, 32'h3C);
        exp_acc(1, 1'b0, 1'b1, 32'h44, 0);
        IN_ADDR = {32'h44, 32'h40};
        IN_RD[0] = 1'b1;
        IN_WR[1] = 1'b1;
        wait_acc(1);
        tick(2);
        chk("full_hold_rd", 64'(OUT_RD), 64'd0);
        chk("full_hold_ardy", 64'(IN_ARDY), 64'd0);
        exp_acc(0, 1'b1, 1'b0, 32'h40, 0);
        respond(32'h1);
        wait_acc(0);
        chk("held_rd_lat", 64'(last_acc - last_rsp), 64'd2);
        respond(32'h2);
        respond(32'h3);
        respond(32'h4);
        respond(32'h5);
        tick(1);

        // Reset while busy with two reads outstanding.
        issue(1, 1'b1, 1'b0, 32'h50);
        issue(0, 1'b1, 1'b0, 32'h54);
        OUT_ARDY = 1'b0;
        IN_ADDR[63:32] = 32'h60;
        IN_RD[1] = 1'b1;
        tick(2);
        chk("busy_rd", 64'(OUT_RD), 64'd1);
        RESET = 1'b1;
        IN_RD = 2'b00;
        tick(1);
        chk("rst_busy_rd", 64'(OUT_RD), 64'd0);
        chk("rst_busy_wr", 64'(OUT_WR), 64'd0);
        RESET = 1'b0;
        OUT_ARDY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            OUT_DRD  = 32'h77 + 32'(k);
            OUT_DRDY = 1'b1;
            #1;
            chk("flushed_drdy", 64'(IN_DRDY), 64'd0);
            tick(1);
        end
        OUT_DRDY = 1'b0;
        exp_acc(0, 1'b0, 1'b1, 32'h70, 0);
        exp_acc(1, 1'b0, 1'b1, 32'h74, 0);
        IN_ADDR = {32'h74, 32'h70};
        IN_WR = 2'b11;
        wait_acc(0);
        wait_acc(1);
        tick(2);

`ifdef NETWORK_MOD_MI_ARB_TIMEOUT_EN
        // Unanswered read expires, late DRDY dropped, next read fine.
        exp_rsp(0, 32'hFFFF_FFFF);
        issue(0, 1'b1, 1'b0, 32'h80);
        tick(20);
        chk("to_latency", 64'(last_rsp - last_acc), 64'd16);
        respond(32'h0000_DEAD);
        tick(1);
        exp_rsp(1, 32'h0000_1234);
        issue(1, 1'b1, 1'b0, 32'h84);
        tick(2);
        respond(32'h0000_1234);
        tick(2);
`endif

        chk("acc_q_left", 64'(accq.size()), 64'd0);
        chk("rsp_q_left", 64'(rspq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/network_mod_mi_arb.md
# network_mod_mi_arb

Round-robin arbiter sharing one MI (memory-interface) bus toward the Ethernet PHY/PMD management space between several MI requesters inside the network module, such as the host MI and an autonomous link-monitor FSM. It serialises requests onto the shared bus and tracks outstanding reads in order. Each DRDY response is routed back to the requester that issued the read. It sits between the network-module MI splitter outputs and the PHY MI port.

## Interface
Parameters:
- REQUESTERS, 2, number of MI requesters (>=2)
- MI_DATA_WIDTH, 32, MI data width
- MI_ADDR_WIDTH, 32, MI address width
- MAX_OUTSTANDING, 4, max reads issued without DRDY (power of 2)
- TIMEOUT, 1024, read-response timeout in cycles (used only with timeout feature)

Ports (MI semantics: RD/WR held with stable ADDR/DWR/BE until ARDY; DRDY returns read data in issue order):
- CLK  in  1  module clock
- RESET  in  1  synchronous, active-high reset
- IN_DWR  in  REQUESTERS*MI_DATA_WIDTH  write data per requester
- IN_ADDR  in  REQUESTERS*MI_ADDR_WIDTH  address per requester
- IN_BE  in  REQUESTERS*MI_DATA_WIDTH/8  byte enables per requester
- IN_RD / IN_WR  in  REQUESTERS  read/write request per requester
- IN_ARDY  out  REQUESTERS  request accepted, per requester
- IN_DRD  out  REQUESTERS*MI_DATA_WIDTH  read data per requester
- IN_DRDY  out  REQUESTERS  read data valid per requester
- OUT_DWR, OUT_ADDR, OUT_BE, OUT_RD, OUT_WR  out  shared-bus request
- OUT_ARDY  in  1  shared-bus accept
- OUT_DRD  in  MI_DATA_WIDTH  shared-bus read data
- OUT_DRDY  in  1  shared-bus read data valid

## Operation
- FSM has two states: IDLE and BUSY. Reset puts it in IDLE.
- IDLE: eligible requesters are those with WR=1, or RD=1 while the response FIFO is not full. Pick the first eligible index at or after the pointer, with wrap-around, and register it as the grant. Go to BUSY. With no eligible requester, stay in IDLE.
- BUSY: OUT_* combinationally mirror the granted requester's inputs, and OUT_ARDY is routed to IN_ARDY[grant]. On OUT_ARDY=1:
  - if it was a read, push the grant ID into the response FIFO (depth MAX_OUTSTANDING);
  - set the pointer to grant+1 (mod REQUESTERS);
  - return to IDLE.
- RD and WR both set: treat as a read, forward both unchanged.
- OUT_DRDY=1 with a non-empty FIFO: pop the head; IN_DRDY[head]=1 and IN_DRD[head]=OUT_DRD, same cycle (combinational). Non-selected IN_DRD=0.
- OUT_DRDY=1 with an empty FIFO: the response is ignored and routed to no requester.
- Push and pop may happen in the same cycle; occupancy is unchanged.
- Writes are never blocked by a full FIFO.
- Reset in any state:
  - FSM to IDLE, pointer to 0;
  - FIFO flushed, pending responses lost;
  - counters cleared.
- Reset values of outputs: OUT_RD=OUT_WR=0, IN_ARDY=0, IN_DRDY=0, IN_DRD=0. OUT_DWR, OUT_ADDR and OUT_BE mirror requester 0.
- In IDLE, OUT_RD=OUT_WR=0.

## Timing
- Request first seen high in cycle n gives grant and OUT_RD/OUT_WR in cycle n+1. IN_ARDY equals OUT_ARDY in the same cycle.
- At least one IDLE bubble per transaction, so peak throughput is one transaction per 2 cycles.
- Read data path latency is 0 cycles, from OUT_DRDY to IN_DRDY.
- FIFO full (MAX_OUTSTANDING reads pending) masks read eligibility from the cycle after the filling push.

## Configuration
- Macro NETWORK_MOD_MI_ARB_TIMEOUT_EN defined:
  - a counter runs while the FIFO is non-empty and restarts at every pop;
  - when it reaches TIMEOUT, pop the head, drive IN_DRDY[head]=1 with IN_DRD all ones, and increment a stale counter (width clog2(MAX_OUTSTANDING)+1, saturating);
  - each later OUT_DRDY with stale>0 is discarded and decrements stale; it takes priority over FIFO routing;
  - OUT_DRDY and expiry in the same cycle: OUT_DRDY wins and is serviced normally.
- Macro undefined: no counters exist, and reads wait indefinitely for DRDY.

## Test plan
- REQUESTERS=2, both issue WR continuously, OUT_ARDY tied 1 -> grants alternate 0,1,0,1; each IN_ARDY pulses every 4 cycles; a write is issued every 2 cycles.
- Requester 1 reads 0x10, then requester 0 reads 0x20; slave returns 0xAAAA then 0xBBBB -> IN_DRDY[1] gets 0xAAAA, IN_DRDY[0] gets 0xBBBB, in order.
- 4 reads pending, 5th read plus a write pending -> the write is granted, the read is held until the first DRDY, then granted the next IDLE.
- OUT_DRDY with an empty FIFO -> no IN_DRDY asserted, state unchanged.
- RESET during BUSY with 2 reads pending -> OUT_RD=0 next cycle; later OUT_DRDY pulses are ignored; the pointer restarts at requester 0.
- With TIMEOUT_EN and TIMEOUT=16: read with no response -> IN_DRDY=1 with 0xFFFFFFFF at cycle 16 after the push; a late OUT_DRDY is discarded; a following read is answered correctly.
